// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory stage behind the EX/MEM pipeline register. It runs loads and stores
// on the data-memory bus with a req/ready handshake. While an access is in
// flight it holds the upstream pipeline, and it produces registered writeback
// values for the MEM/WB boundary. Misaligned, illegal and timed-out accesses
// are flagged as faults.
//
// States:
//   S_IDLE | no access in flight; decode the EX/MEM slot every cycle
//   S_REQ  | bus request outstanding; wait for dmem_ready or the timeout
//
// Ports:
//   clock, reset            system clock; asynchronous active-low reset
//   in_valid .. in_MemWr    EX/MEM slot: valid, ALU result/address, store
//                           data, MemOp, rd and control bits
//   stall                   upstream must hold the EX/MEM contents
//   dmem_req/we/addr/
//   wdata/wstrb             data-memory request (addr is word aligned)
//   dmem_ready, dmem_rdata  bus completion and read data
//   wb_valid/data/rd/RegWr  registered writeback slot
//   mem_fault, fault_cause  fault pulse; cause 01 misaligned, 10 timeout,
//                           11 illegal (the cause is held until the next fault)
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_ALUout,
    input  logic [31:0] in_busB,
    input  logic [2:0]  in_MemOp,
    input  logic [4:0]  in_rd,
    input  logic        in_MemtoReg,
    input  logic        in_RegWr,
    input  logic        in_MemWr,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_RegWr,
    output logic        mem_fault,
    output logic [1:0]  fault_cause
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // captured access
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          we_q, we_d;
    logic [2:0]    op_q, op_d;
    logic [4:0]    rd_q, rd_d;
    logic          regwr_q, regwr_d;
    logic          load_q, load_d;

    // writeback slot
    logic          wb_valid_q, wb_valid_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_regwr_q, wb_regwr_d;
    logic          fault_q, fault_d;
    logic [1:0]    cause_q, cause_d;

    logic          mem_op;
    logic          op_legal;
    logic          illegal;
    logic          misaligned;
    logic          accept;
    logic          last_wait;
    logic [1:0]    off;
    logic [3:0]    strb_in;
    logic [31:0]   wdata_in;
    logic [31:0]   load_val;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    // ---------------- request decode ----------------
    assign mem_op = in_valid & (in_MemtoReg | in_MemWr);
    assign off    = in_ALUout[1:0];

    always_comb begin
        op_legal = 1'b0;
        case (in_MemOp)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

    assign illegal    = ~op_legal | (in_MemtoReg & in_MemWr);
    // op[1:0] is the access size for every legal op (00 byte, 01 half, 10 word)
    assign misaligned = ((in_MemOp[1:0] == 2'b01) & off[0]) |
                        ((in_MemOp[1:0] == 2'b10) & (off != 2'b00));
    assign accept     = (state_q == S_IDLE) & mem_op & ~illegal & ~misaligned;

    always_comb begin
        strb_in  = 4'b1111;
        wdata_in = in_busB;
        case (in_MemOp[1:0])
            2'b00: begin
                strb_in  = 4'b0001 << off;
                wdata_in = {4{in_busB[7:0]}};
            end
            2'b01: begin
                strb_in  = off[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{in_busB[15:0]}};
            end
            default: begin
                strb_in  = 4'b1111;
                wdata_in = in_busB;
            end
        endcase
    end

    // ---------------- load lane extraction ----------------
    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
    end

    assign ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_val = dmem_rdata;
        case (op_q[1:0])
            2'b00: load_val = op_q[2] ? {24'h0, ld_byte}
                                      : {{24{ld_byte[7]}}, ld_byte};
            2'b01: load_val = op_q[2] ? {16'h0, ld_half}
                                      : {{16{ld_half[15]}}, ld_half};
            default: load_val = dmem_rdata;
        endcase
    end

    // The last waiting cycle aborts at its edge, so upstream may advance in it.
    assign last_wait = (state_q == S_REQ) & ~dmem_ready & (cnt_q == CNT_LAST);

    // stall is gated by reset so that it reads 0 while reset is held.
    assign stall = reset & (accept | ((state_q == S_REQ) & ~dmem_ready & ~last_wait));

    // ---------------- next state ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        we_d       = we_q;
        op_d       = op_q;
        rd_d       = rd_q;
        regwr_d    = regwr_q;
        load_d     = load_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_regwr_d = 1'b0;
        fault_d    = 1'b0;
        cause_d    = cause_q;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    if (illegal | misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = in_ALUout;
                        wb_rd_d    = in_rd;
                        fault_d    = 1'b1;
                        cause_d    = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        addr_d  = in_ALUout;
                        wdata_d = wdata_in;
                        wstrb_d = in_MemWr ? strb_in : 4'b0000;
                        we_d    = in_MemWr;
                        op_d    = in_MemOp;
                        rd_d    = in_rd;
                        regwr_d = in_RegWr;
                        load_d  = in_MemtoReg;
                    end
                end else if (in_valid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = in_ALUout;
                    wb_rd_d    = in_rd;
                    wb_regwr_d = in_RegWr;
                end
            end
            S_REQ: begin
                if (dmem_ready) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_regwr_d = regwr_q & load_q;
                    wb_data_d  = load_q ? load_val : addr_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = addr_q;
                    fault_d    = 1'b1;
                    cause_d    = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            regwr_q    <= 1'b0;
            load_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_regwr_q <= 1'b0;
            fault_q    <= 1'b0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            we_q       <= we_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            regwr_q    <= regwr_d;
            load_q     <= load_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_regwr_q <= wb_regwr_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
        end
    end

    assign dmem_req    = (state_q == S_REQ);
    assign dmem_we     = we_q;
    assign dmem_addr   = {addr_q[31:2], 2'b00};
    assign dmem_wdata  = wdata_q;
    assign dmem_wstrb  = wstrb_q;

    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_RegWr    = wb_regwr_q;
    assign mem_fault   = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: random and directed instructions. For every
// instruction the driver works out the whole cycle-by-cycle outcome from the
// instruction and the bus latency it will apply. Those per-cycle expectations
// go into a queue, and a separate compare process checks the DUT against them.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_ALUout;
    logic [31:0] in_busB;
    logic [2:0]  in_MemOp;
    logic [4:0]  in_rd;
    logic        in_MemtoReg;
    logic        in_RegWr;
    logic        in_MemWr;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_RegWr;
    logic        mem_fault;
    logic [1:0]  fault_cause;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ALUout(in_ALUout), .in_busB(in_busB),
        .in_MemOp(in_MemOp), .in_rd(in_rd), .in_MemtoReg(in_MemtoReg),
        .in_RegWr(in_RegWr), .in_MemWr(in_MemWr),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_RegWr(wb_RegWr), .mem_fault(mem_fault), .fault_cause(fault_cause)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall, req, chk_bus, we;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        logic        wbv, known;
        logic [31:0] wbd;
        logic [4:0]  wbrd;
        logic        wbrw, flt;
        logic [1:0]  cause;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int n_stall, n_req;

    // model of the registered outputs visible in the current cycle
    logic        m_wbv, m_known, m_wbrw, m_flt;
    logic [31:0] m_wbd;
    logic [4:0]  m_wbrd;
    logic [1:0]  m_cause;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_ext(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] rdata);
        int          sz;
        logic [31:0] sh, mask, v;
        sz = 1 << op[1:0];
        if (sz == 4) return rdata;
        sh   = rdata >> (8 * off);
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v    = sh & mask;
        if (!op[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Push this cycle's expectation, then sample stall/req at +7.
    task automatic cyc(input logic s, input logic r, input logic cb, input logic we,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        exp_t e;
        e.stall = s; e.req = r; e.chk_bus = cb; e.we = we;
        e.addr = a; e.wdata = wd; e.wstrb = ws;
        e.wbv = m_wbv; e.known = m_known; e.wbd = m_wbd; e.wbrd = m_wbrd;
        e.wbrw = m_wbrw; e.flt = m_flt; e.cause = m_cause;
        q.push_back(e);
        #5;
        if (stall)    n_stall++;
        if (dmem_req) n_req++;
    endtask

    task automatic nxt();
        @(posedge clock);
        #2;
    endtask

    task automatic model_reset();
        m_wbv = 0; m_known = 1; m_wbd = 0; m_wbrd = 0;
        m_wbrw = 0; m_flt = 0; m_cause = 0;
    endtask

    // Called at posedge+2. Runs one EX/MEM slot to completion and returns at
    // posedge+2 of the cycle whose registered outputs show its writeback.
    task automatic run_op(input logic v, input logic [31:0] alu, input logic [31:0] busb,
                          input logic [2:0] op, input logic [4:0] rd, input logic m2r,
                          input logic rwr, input logic mwr, input int lat,
                          input logic [31:0] rdata);
        logic        mop, ill, mis;
        int          sz;
        logic [1:0]  off;
        logic [3:0]  ws;
        logic [31:0] wd, wa;
        n_stall = 0; n_req = 0;
        in_valid = v; in_ALUout = alu; in_busB = busb; in_MemOp = op; in_rd = rd;
        in_MemtoReg = m2r; in_RegWr = rwr; in_MemWr = mwr;
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        mop = v & (m2r | mwr);
        ill = !(op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (m2r && mwr);
        sz  = 1 << op[1:0];
        off = alu[1:0];
        mis = (sz == 2 && off[0]) || (sz == 4 && off != 2'b00);
        ws  = mwr ? 4'(((1 << sz) - 1) << off) : 4'b0000;
        wd  = (sz == 1) ? {4{busb[7:0]}} : (sz == 2) ? {2{busb[15:0]}} : busb;
        wa  = {alu[31:2], 2'b00};
        if (!mop) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (v) begin
                m_wbv = 1; m_known = 1; m_wbd = alu; m_wbrd = rd; m_wbrw = rwr;
            end else begin
                m_wbv = 0; m_wbrw = 0;
            end
            m_flt = 0;
            nxt();
        end else if (ill || mis) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            m_wbv = 1; m_known = 0; m_wbrw = 0; m_flt = 1;
            m_cause = ill ? 2'b11 : 2'b01;
            nxt();
        end else begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            m_wbv = 0; m_wbrw = 0; m_flt = 0;
            nxt();
            for (int k = 0; k <= TO; k++) begin
                if (k == lat) begin
                    dmem_ready = 1; dmem_rdata = rdata;
                    cyc(0, 1, 1, mwr, wa, wd, ws);
                    m_wbv = 1; m_known = 1; m_wbrd = rd; m_flt = 0;
                    if (m2r) begin
                        m_wbd = ld_ext(op, off, rdata); m_wbrw = rwr;
                    end else begin
                        m_wbd = alu; m_wbrw = 0;
                    end
                    nxt();
                    break;
                end
                dmem_ready = 0; dmem_rdata = $urandom;
                if (k == TO - 1) begin
                    cyc(0, 1, 1, mwr, wa, wd, ws);
                    m_wbv = 1; m_known = 0; m_wbrw = 0; m_flt = 1; m_cause = 2'b10;
                    nxt();
                    break;
                end
                cyc(1, 1, 1, mwr, wa, wd, ws);
                m_wbv = 0; m_wbrw = 0; m_flt = 0;
                nxt();
            end
        end
    endtask

    // compare process
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #7;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", stall, e.stall);
                chk("dmem_req", dmem_req, e.req);
                if (e.chk_bus) begin
                    chk("dmem_we", dmem_we, e.we);
                    chk("dmem_addr", dmem_addr, e.addr);
                    chk("dmem_wstrb", dmem_wstrb, e.wstrb);
                    if (e.we) chk("dmem_wdata", dmem_wdata, e.wdata);
                end
                chk("wb_valid", wb_valid, e.wbv);
                chk("wb_RegWr", wb_RegWr, e.wbrw);
                chk("mem_fault", mem_fault, e.flt);
                chk("fault_cause", fault_cause, e.cause);
                if (e.known) begin
                    chk("wb_data", wb_data, e.wbd);
                    chk("wb_rd", wb_rd, e.wbrd);
                end
            end
        end
    end

    initial begin
        int          lat;
        logic [2:0]  op;
        logic [31:0] alu;
        logic        m2r, mwr;
        logic [2:0]  legal_ops [5];
        legal_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        // reset with a legal load presented: stall must still read 0
        reset = 0;
        in_valid = 1; in_ALUout = 32'h40; in_busB = 0; in_MemOp = 3'b010; in_rd = 3;
        in_MemtoReg = 1; in_RegWr = 1; in_MemWr = 0; dmem_ready = 0; dmem_rdata = 0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mem_fault", mem_fault, 0);
        chk("rst_fault_cause", fault_cause, 0);
        chk("rst_dmem_wstrb", dmem_wstrb, 0);
        model_reset();
        nxt();
        reset = 1;

        // ALU op
        run_op(1, 32'h1234, 0, 3'b010, 5, 0, 1, 0, 0, 0);
        chk("alu_stall_cnt", n_stall, 0);
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_wb_rd", wb_rd, 5);
        chk("alu_wb_RegWr", wb_RegWr, 1);

        // LB / LBU at 0x1003, ready after 3 waiting cycles
        run_op(1, 32'h1003, 0, 3'b000, 6, 1, 1, 0, 3, 32'h80FF_FFFF);
        chk("lb_stall_cnt", n_stall, 4);
        chk("lb_addr", dmem_addr, 32'h1000);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        run_op(1, 32'h1003, 0, 3'b100, 6, 1, 1, 0, 3, 32'h80FF_FFFF);
        chk("lbu_wb_data", wb_data, 32'h0000_0080);

        // SH at 0x2002
        run_op(1, 32'h2002, 32'hABCD_1234, 3'b001, 7, 0, 1, 1, 0, 0);
        chk("sh_we", dmem_we, 1);
        chk("sh_wstrb", dmem_wstrb, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'h1234_1234);
        chk("sh_wb_RegWr", wb_RegWr, 0);

        // misaligned LW
        run_op(1, 32'h3001, 0, 3'b010, 8, 1, 1, 0, 0, 0);
        chk("mis_req_cnt", n_req, 0);
        chk("mis_fault", mem_fault, 1);
        chk("mis_cause", fault_cause, 2'b01);
        chk("mis_wb_RegWr", wb_RegWr, 0);
        chk("mis_wb_valid", wb_valid, 1);

        // timeout
        run_op(1, 32'h40, 0, 3'b010, 9, 1, 1, 0, 99, 0);
        chk("to_req_cnt", n_req, 4);
        chk("to_stall_cnt", n_stall, 4);
        chk("to_req_drop", dmem_req, 0);
        chk("to_fault", mem_fault, 1);
        chk("to_cause", fault_cause, 2'b10);
        chk("to_wb_RegWr", wb_RegWr, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 4)
                0: begin m2r = 0; mwr = 0; end
                1: begin m2r = 1; mwr = 0; end
                2: begin m2r = 0; mwr = 1; end
                default: begin m2r = 1'($urandom); mwr = 1'($urandom); end
            endcase
            op  = ($urandom % 6 == 0) ? 3'($urandom) : legal_ops[$urandom % 5];
            alu = $urandom;
            if ($urandom % 2) alu[1:0] = 2'b00;
            lat = ($urandom % 5 == 0) ? 4 + int'($urandom % 3) : int'($urandom % 4);
            run_op(($urandom % 8) != 0, alu, $urandom, op, 5'($urandom), m2r,
                   1'($urandom), mwr, lat, $urandom);
        end

        // reset while a request is outstanding
        n_stall = 0; n_req = 0;
        in_valid = 1; in_ALUout = 32'h40; in_busB = 0; in_MemOp = 3'b010; in_rd = 7;
        in_MemtoReg = 1; in_RegWr = 1; in_MemWr = 0; dmem_ready = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        m_wbv = 0; m_wbrw = 0; m_flt = 0;
        nxt();
        cyc(1, 1, 1, 0, 32'h40, 0, 4'b0000);
        #1;
        reset = 0;
        #1;
        chk("rreq_dmem_req", dmem_req, 0);
        chk("rreq_stall", stall, 0);
        chk("rreq_wb_valid", wb_valid, 0);
        nxt();
        chk("rreq_wb_valid_after_edge", wb_valid, 0);
        chk("rreq_dmem_req_after_edge", dmem_req, 0);
        reset = 1;
        model_reset();
        run_op(1, 32'h55, 0, 3'b000, 9, 0, 1, 0, 0, 0);
        chk("post_rst_wb_valid", wb_valid, 1);
        chk("post_rst_wb_data", wb_data, 32'h55);
        chk("post_rst_wb_rd", wb_rd, 9);

        run_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #8;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline register.
- Takes the registered ALU result, store data, MemOp, rd and control bits, and runs loads/stores on the data-memory bus through a req/ready handshake.
- Holds the upstream pipeline with stall while an access is in flight, and produces registered writeback values for the MEM/WB boundary.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 255: maximum cycles spent waiting for dmem_ready before the access is aborted; counter width is $clog2(TIMEOUT+1).

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM slot holds a real instruction; 0 means bubble
- in_ALUout  in  32  byte address for mem ops, result value otherwise
- in_busB  in  32  store data
- in_MemOp  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- in_rd  in  5  destination register
- in_MemtoReg  in  1  load
- in_RegWr  in  1  writes rd
- in_MemWr  in  1  store
- stall  out  1  upstream must hold the EX/MEM contents
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables (0000 for reads)
- dmem_ready  in  1  bus completes the request this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready=1
- wb_valid  out  1  one-cycle pulse: writeback slot updated
- wb_data  out  32  load result or passed-through ALUout
- wb_rd  out  5  destination register
- wb_RegWr  out  1  register write enable, only high together with wb_valid
- mem_fault  out  1  one-cycle pulse with wb_valid on a faulting op
- fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal; held until the next fault

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE and the timeout counter clears.
  - All outputs are 0 immediately, including dmem_req; stall is 0.
  - A bus access in flight is abandoned and no writeback is produced.
- mem_op = in_valid & (in_MemtoReg | in_MemWr).
- Faults:
  - Illegal: in_MemOp not in the legal set, or MemtoReg & MemWr both set.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- FSM state IDLE:
  - Non-memory instruction with in_valid=1: at the next edge wb_valid=1, wb_data=in_ALUout, wb_rd=in_rd, wb_RegWr=in_RegWr. Latency 1 cycle, stall=0.
  - in_valid=0: wb_valid=0 and wb_RegWr=0 next cycle; wb_data and wb_rd hold.
  - mem_op with a fault:
    - No bus request is issued.
    - Next edge: wb_valid=1, wb_RegWr=0, mem_fault=1, fault_cause set; stall=0.
    - Illegal takes priority over misaligned.
  - mem_op, legal: stall=1 combinationally. At the edge, address, data, strobes, op and rd are captured and the FSM moves to REQ.
- FSM state REQ:
  - dmem_req=1; address, data and strobes are stable from registers.
  - stall = ~dmem_ready.
  - Edge with dmem_ready=1: return to IDLE. wb_valid=1, wb_rd=captured rd, wb_RegWr=captured RegWr & load. For a load, wb_data is the extracted lane; for a store, wb_data is the captured address.
  - The counter increments each REQ cycle without ready. When it reaches TIMEOUT: abort, dmem_req drops at that edge, wb_valid=1, wb_RegWr=0, mem_fault=1, cause 10, return to IDLE. stall is 0 in that final cycle.
- Minimum load/store latency: 2 edges (accept, then ready).
- Lane rules, where off = addr[1:0]:
  - B: wstrb = 0001<<off, wdata = {4{busB[7:0]}}.
  - H: wstrb = 0011 or 1100 by addr[1], wdata = {2{busB[15:0]}}.
  - W: wstrb = 1111.
  - Load extraction: byte/half selected by off; B/H sign-extend; BU/HU zero-extend.
- dmem_ready while in IDLE is ignored.
- A new instruction accepted in the same cycle wb_valid pulses is legal; there are no bubbles between back-to-back ops.

Test Plan:
- ALU op (ALUout=0x1234, rd=5, RegWr=1) -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, wb_RegWr=1; stall never high.
- LB at 0x1003, dmem_rdata=0x80FFFFFF, ready 3 cycles after req -> stall high 4 cycles, dmem_addr=0x1000, wb_data=0xFFFFFF80; repeat with LBU -> 0x00000080.
- SH at 0x2002, busB=0xABCD1234 -> dmem_we=1, wstrb=1100, wdata=0x12341234; wb_RegWr=0.
- LW at 0x3001 -> no dmem_req, mem_fault=1, fault_cause=01, wb_RegWr=0, 1-cycle latency.
- TIMEOUT=4, LW at 0x40 with ready held low -> dmem_req high 4 cycles then drops, mem_fault=1, cause=10, stall released.
- Reset pulled low while in REQ -> dmem_req and stall go 0 immediately with no wb_valid; after release, an ALU op completes normally.
